// File: rtl/ciphertext_serializer_if.sv
// Byte-stream interface between the ciphertext serializer and its encryptor/pin-side neighbours.
// The master modport is the serializer's view; the slave modport is the environment's.
interface ciphertext_serializer_if #(
    parameter int unsigned MSG_SIZE = 512
);
    localparam int unsigned NUM_BYTES = MSG_SIZE / 8;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES) + 1;

    logic                iEncrypt_done;
    logic [MSG_SIZE-1:0] iCiphertext;
    logic                iReady;
    logic [7:0]          oData;
    logic                oValid;
    logic [CNT_W-1:0]    oByte_count;
    logic                oBusy;
    logic                oSend_done;

    modport master (
        input  iEncrypt_done, iCiphertext, iReady,
        output oData, oValid, oByte_count, oBusy, oSend_done
    );

    modport slave (
        output iEncrypt_done, iCiphertext, iReady,
        input  oData, oValid, oByte_count, oBusy, oSend_done
    );
endinterface

// File: rtl/ciphertext_serializer.sv
// Captures the encryptor's ciphertext once its done flag is seen and streams it out
// MSB byte first over valid/ready, then holds a sticky done until upstream done drops.
module ciphertext_serializer #(
    parameter int unsigned MSG_SIZE = 512
) (
    input logic iClk,
    input logic iRst,
    ciphertext_serializer_if.master bus
);
    localparam int unsigned NUM_BYTES = MSG_SIZE / 8;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [MSG_SIZE-1:0] shiftReg;
    logic [MSG_SIZE-1:0] shiftRegNext;
    logic [7:0]          dataNext;
    logic                validNext;
    logic                busyNext;
    logic                sendDoneNext;
    logic [CNT_W-1:0]    countNext;

    // State and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state           <= IDLE;
            shiftReg        <= '0;
            bus.oData       <= '0;
            bus.oValid      <= 1'b0;
            bus.oByte_count <= '0;
            bus.oBusy       <= 1'b0;
            bus.oSend_done  <= 1'b0;
        end else begin
            state           <= stateNext;
            shiftReg        <= shiftRegNext;
            bus.oData       <= dataNext;
            bus.oValid      <= validNext;
            bus.oByte_count <= countNext;
            bus.oBusy       <= busyNext;
            bus.oSend_done  <= sendDoneNext;
        end
    end

    // Next state and next output values; everything holds unless a transition says otherwise.
    always_comb begin
        stateNext    = state;
        shiftRegNext = shiftReg;
        dataNext     = bus.oData;
        validNext    = bus.oValid;
        busyNext     = bus.oBusy;
        sendDoneNext = bus.oSend_done;
        countNext    = bus.oByte_count;

        case (state)
            IDLE: begin
                dataNext  = '0;
                validNext = 1'b0;
                busyNext  = 1'b0;
                if (bus.iEncrypt_done) begin
                    shiftRegNext = bus.iCiphertext;
                    dataNext     = bus.iCiphertext[MSG_SIZE-1 -: 8];
                    validNext    = 1'b1;
                    busyNext     = 1'b1;
                    countNext    = '0;
                    stateNext    = SEND;
                end
            end

            SEND: begin
                if (bus.oValid && bus.iReady) begin
                    if (bus.oByte_count == CNT_W'(NUM_BYTES - 1)) begin
                        countNext    = CNT_W'(NUM_BYTES);
                        validNext    = 1'b0;
                        dataNext     = '0;
                        busyNext     = 1'b0;
                        sendDoneNext = 1'b1;
                        stateNext    = DONE;
                    end else begin
                        // The byte on oData sits at the top of shiftReg; the next one is just below it.
                        shiftRegNext = shiftReg << 8;
                        dataNext     = shiftReg[MSG_SIZE-9 -: 8];
                        countNext    = bus.oByte_count + CNT_W'(1);
                    end
                end
            end

            DONE: begin
                validNext = 1'b0;
                if (!bus.iEncrypt_done) begin
                    sendDoneNext = 1'b0;
                    countNext    = '0;
                    stateNext    = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ciphertext_serializer.sv
// Directed bench for ciphertext_serializer: a 512-bit instance for the main scenarios and a
// 32-bit instance for the small-parameter byte-order case.
module tb_ciphertext_serializer;
    logic iClk;
    logic iRst;

    int nChecks = 0;
    int nErrors = 0;

    logic [7:0] expMsg [64];

    ciphertext_serializer_if #(.MSG_SIZE(512)) bus0 ();
    ciphertext_serializer_if #(.MSG_SIZE(32))  bus1 ();

    ciphertext_serializer #(.MSG_SIZE(512)) dut0 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus0)
    );

    ciphertext_serializer #(.MSG_SIZE(32)) dut1 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic readyAt(input int pat, input int cyc);
        if (pat == 0) return 1'b1;
        case (cyc % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic setCounting();
        for (int k = 0; k < 64; k++) begin
            bus0.iCiphertext[511-8*k -: 8] = 8'(k);
            expMsg[k] = 8'(k);
        end
    endtask

    task automatic setFill(input logic [7:0] b);
        for (int k = 0; k < 64; k++) begin
            bus0.iCiphertext[511-8*k -: 8] = b;
            expMsg[k] = b;
        end
    endtask

    // Accepts bytes first..last from dut0, checking the offered byte every cycle (stalled or not).
    task automatic recvMsg(input int pat, input int first, input int last);
        int idx;
        int cyc;
        idx = first;
        cyc = 0;
        while (idx <= last && cyc < 400) begin
            bus0.iReady = readyAt(pat, cyc);
            checkVal("valid", 32'(bus0.oValid), 32'd1);
            checkVal("busy", 32'(bus0.oBusy), 32'd1);
            checkVal("data", 32'(bus0.oData), 32'(expMsg[idx]));
            checkVal("count", 32'(bus0.oByte_count), 32'(idx));
            if (bus0.oValid && bus0.iReady) idx++;
            tick();
            cyc++;
        end
        if (idx <= last) checkVal("recv_timeout", 32'(idx), 32'(last + 1));
    endtask

    task automatic checkDone0();
        checkVal("done_flag", 32'(bus0.oSend_done), 32'd1);
        checkVal("done_count", 32'(bus0.oByte_count), 32'd64);
        checkVal("done_valid", 32'(bus0.oValid), 32'd0);
        checkVal("done_busy", 32'(bus0.oBusy), 32'd0);
        checkVal("done_data", 32'(bus0.oData), 32'd0);
    endtask

    task automatic checkZero0(input string tag);
        checkVal({tag, "_data"}, 32'(bus0.oData), 32'd0);
        checkVal({tag, "_valid"}, 32'(bus0.oValid), 32'd0);
        checkVal({tag, "_count"}, 32'(bus0.oByte_count), 32'd0);
        checkVal({tag, "_busy"}, 32'(bus0.oBusy), 32'd0);
        checkVal({tag, "_done"}, 32'(bus0.oSend_done), 32'd0);
    endtask

    task automatic rearm0();
        bus0.iEncrypt_done = 1'b0;
        tick();
        bus0.iEncrypt_done = 1'b1;
        tick();
    endtask

    logic [7:0] exp32 [4];

    initial begin
        iRst               = 1'b1;
        bus0.iEncrypt_done = 1'b0;
        bus0.iCiphertext   = '0;
        bus0.iReady        = 1'b0;
        bus1.iEncrypt_done = 1'b0;
        bus1.iCiphertext   = '0;
        bus1.iReady        = 1'b0;
        exp32[0] = 8'hDE; exp32[1] = 8'hAD; exp32[2] = 8'hBE; exp32[3] = 8'hEF;

        tick();
        tick();
        checkZero0("reset");
        checkVal("reset32_valid", 32'(bus1.oValid), 32'd0);
        checkVal("reset32_count", 32'(bus1.oByte_count), 32'd0);

        // Back-to-back stream, byte k = k.
        setCounting();
        iRst               = 1'b0;
        bus0.iEncrypt_done = 1'b1;
        bus0.iReady        = 1'b1;
        checkVal("t1_prevalid", 32'(bus0.oValid), 32'd0);
        tick();
        recvMsg(0, 0, 63);
        checkDone0();

        // Sticky done with upstream done held high, then re-arm with 0xA5 fill.
        for (int i = 0; i < 20; i++) begin
            tick();
            checkVal("hold_valid", 32'(bus0.oValid), 32'd0);
            checkVal("hold_done", 32'(bus0.oSend_done), 32'd1);
            checkVal("hold_count", 32'(bus0.oByte_count), 32'd64);
        end
        bus0.iEncrypt_done = 1'b0;
        tick();
        checkZero0("rearm");
        setFill(8'hA5);
        bus0.iEncrypt_done = 1'b1;
        tick();
        recvMsg(0, 0, 63);
        checkDone0();

        // Stalling ready pattern 1,0,0,1,0,1.
        setCounting();
        rearm0();
        recvMsg(1, 0, 63);
        checkDone0();

        // Reset after 10 accepted bytes, upstream done still high.
        rearm0();
        recvMsg(0, 0, 9);
        iRst = 1'b1;
        tick();
        checkZero0("midrst");
        iRst = 1'b0;
        tick();
        recvMsg(0, 0, 63);
        checkDone0();

        // Upstream word changes mid-send; captured copy must still be used.
        rearm0();
        recvMsg(0, 0, 5);
        for (int k = 0; k < 64; k++) bus0.iCiphertext[511-8*k -: 8] = 8'hFF;
        recvMsg(0, 6, 63);
        checkDone0();

        // 32-bit instance, MSB-first byte order.
        bus1.iCiphertext   = 32'hDEADBEEF;
        bus1.iReady        = 1'b1;
        bus1.iEncrypt_done = 1'b1;
        checkVal("s32_prevalid", 32'(bus1.oValid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkVal("s32_valid", 32'(bus1.oValid), 32'd1);
            checkVal("s32_data", 32'(bus1.oData), 32'(exp32[i]));
            checkVal("s32_count", 32'(bus1.oByte_count), 32'(i));
            tick();
        end
        checkVal("s32_done", 32'(bus1.oSend_done), 32'd1);
        checkVal("s32_endcount", 32'(bus1.oByte_count), 32'd4);
        checkVal("s32_endvalid", 32'(bus1.oValid), 32'd0);
        checkVal("s32_endbusy", 32'(bus1.oBusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
